// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions: opcode map, mnemonic codes, field layout and loader FSM states.
// INSTR_ENC_READBACK_EN adds the VERIFY state used by the read-back variant of the loader.
package mips_isa_pkg;

   localparam int WORD_W  = 32;
   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int TGT_W   = 26;

   localparam int OP_LSB    = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_LSB = 6;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_J    = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b010000;
   localparam logic [OP_W-1:0] OP_SUBI = 6'b010001;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b010010;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b001000;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b001001;
   localparam logic [OP_W-1:0] OP_BGT  = 6'b001010;
   localparam logic [OP_W-1:0] OP_BGE  = 6'b001011;
   localparam logic [OP_W-1:0] OP_BLE  = 6'b001100;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

   typedef enum logic [3:0] {
      MN_R    = 4'd0,
      MN_ADDI = 4'd1,
      MN_SUBI = 4'd2,
      MN_ANDI = 4'd3,
      MN_BEQ  = 4'd4,
      MN_BNE  = 4'd5,
      MN_BGT  = 4'd6,
      MN_BGE  = 4'd7,
      MN_BLE  = 4'd8,
      MN_LW   = 4'd9,
      MN_SW   = 4'd10,
      MN_J    = 4'd11
   } mnem_e;

`ifdef INSTR_ENC_READBACK_EN
   typedef enum logic [2:0] {ST_IDLE, ST_ACCEPT, ST_WRITE, ST_VERIFY, ST_FIN} state_e;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_ACCEPT, ST_WRITE, ST_FIN} state_e;
`endif

   // Opcode for the I-type mnemonics; anything else maps to the R opcode.
   function automatic logic [OP_W-1:0] itype_op(input logic [3:0] m);
      case (m)
         MN_ADDI: return OP_ADDI;
         MN_SUBI: return OP_SUBI;
         MN_ANDI: return OP_ANDI;
         MN_BEQ:  return OP_BEQ;
         MN_BNE:  return OP_BNE;
         MN_BGT:  return OP_BGT;
         MN_BGE:  return OP_BGE;
         MN_BLE:  return OP_BLE;
         MN_LW:   return OP_LW;
         MN_SW:   return OP_SW;
         default: return OP_R;
      endcase
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: symbolic instruction fields -> 32-bit word plus an illegal flag.
module instr_field_packer
   import mips_isa_pkg::*;
(
   input  logic [3:0]         mnem,
   input  logic [REG_W-1:0]   rs,
   input  logic [REG_W-1:0]   rt,
   input  logic [REG_W-1:0]   rd,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [IMM_W-1:0]   imm,
   input  logic [TGT_W-1:0]   target,
   output logic [WORD_W-1:0]  word,
   output logic               illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (mnem)
         MN_R:    word = {OP_R, rs, rt, rd, shamt, funct};
         MN_J:    word = {OP_J, target};
         MN_ADDI, MN_SUBI, MN_ANDI, MN_BEQ, MN_BNE,
         MN_BGT, MN_BGE, MN_BLE, MN_LW, MN_SW:
                  word = {itype_op(mnem), rs, rt, imm};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes instruction fields and writes the words sequentially into IMEM from base_addr.
// Define INSTR_ENC_READBACK_EN to add a read-back VERIFY step with a sticky err_verify.
module instr_encode_loader
   import mips_isa_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [3:0]         mnem,
   input  logic [REG_W-1:0]   rs,
   input  logic [REG_W-1:0]   rt,
   input  logic [REG_W-1:0]   rd,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [IMM_W-1:0]   imm,
   input  logic [TGT_W-1:0]   target,
`ifdef INSTR_ENC_READBACK_EN
   input  logic [WORD_W-1:0]  imem_rdata,
   output logic               err_verify,
`endif
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [WORD_W-1:0]  imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               full,
   output logic               err_illegal,
   output logic [ADDR_W:0]    count
);

   localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                full_q, full_d;
   logic                err_q, err_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [WORD_W-1:0]   enc_word;
   logic                enc_illegal;
   logic                end_word;
`ifdef INSTR_ENC_READBACK_EN
   logic                vchk_q, vchk_d;
   logic                verr_q, verr_d;
`endif

   instr_field_packer u_packer (
      .mnem    (mnem),
      .rs      (rs),
      .rt      (rt),
      .rd      (rd),
      .shamt   (shamt),
      .funct   (funct),
      .imm     (imm),
      .target  (target),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      word_d   = word_q;
      last_d   = last_q;
      done_d   = done_q;
      full_d   = full_q;
      err_d    = err_q;
      count_d  = count_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      imem_we  = 1'b0;
      end_word = 1'b0;
`ifdef INSTR_ENC_READBACK_EN
      vchk_d   = 1'b0;
      verr_d   = verr_q;
      // Read data for the address held in VERIFY arrives one cycle later.
      if (vchk_q && (imem_rdata != word_q)) verr_d = 1'b1;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               done_d  = 1'b0;
               full_d  = 1'b0;
               err_d   = 1'b0;
               count_d = '0;
`ifdef INSTR_ENC_READBACK_EN
               verr_d  = 1'b0;
`endif
               state_d = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               if (enc_illegal) begin
                  err_d = 1'b1;
                  if (in_last) state_d = ST_FIN;
               end else begin
                  word_d  = enc_word;
                  last_d  = in_last;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            busy    = 1'b1;
            imem_we = 1'b1;
            count_d = count_q + (ADDR_W+1)'(1);
`ifdef INSTR_ENC_READBACK_EN
            state_d = ST_VERIFY;
`else
            end_word = 1'b1;
`endif
         end
`ifdef INSTR_ENC_READBACK_EN
         ST_VERIFY: begin
            busy     = 1'b1;
            vchk_d   = 1'b1;
            end_word = 1'b1;
         end
`endif
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Address never wraps: the top address ends the session unless it was already last.
      if (end_word) begin
         if (last_q) begin
            state_d = ST_FIN;
         end else if (addr_q == TOP_ADDR) begin
            full_d  = 1'b1;
            state_d = ST_FIN;
         end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_ACCEPT;
         end
      end

      if ((state_d == ST_FIN) && (state_q != ST_FIN)) done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
`ifdef INSTR_ENC_READBACK_EN
         vchk_q  <= 1'b0;
         verr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         last_q  <= last_d;
         done_q  <= done_d;
         full_q  <= full_d;
         err_q   <= err_d;
         count_q <= count_d;
`ifdef INSTR_ENC_READBACK_EN
         vchk_q  <= vchk_d;
         verr_q  <= verr_d;
`endif
      end
   end

   assign imem_addr   = addr_q;
   assign imem_wdata  = word_q;
   assign done        = done_q;
   assign full        = full_q;
   assign err_illegal = err_q;
   assign count       = count_q;
`ifdef INSTR_ENC_READBACK_EN
   assign err_verify  = verr_q;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomised + directed bench for instr_encode_loader against a transaction-level model.
module tb_instr_encode_loader;

   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst, start, in_valid, in_ready, in_last;
   logic [AW-1:0] base_addr;
   logic [3:0] mnem;
   logic [4:0] rs, rt, rd, shamt;
   logic [5:0] funct;
   logic [15:0] imm;
   logic [25:0] target;
   logic imem_we, busy, done, full, err_illegal;
   logic [AW-1:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [AW:0] count;
`ifdef INSTR_ENC_READBACK_EN
   logic [31:0] imem_rdata;
   logic err_verify;
   logic [31:0] mem [2**AW];
   logic corrupt_en;
   logic [AW-1:0] corrupt_addr;
   bit exp_verr;
`endif

   instr_encode_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .target(target),
`ifdef INSTR_ENC_READBACK_EN
      .imem_rdata(imem_rdata), .err_verify(err_verify),
`endif
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .full(full), .err_illegal(err_illegal), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mnem; logic [4:0] rs, rt, rd, shamt;
      logic [5:0] funct; logic [15:0] imm; logic [25:0] target;
   } item_t;
   typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;

   item_t items[$];
   wr_t   exp_q[$];
   wr_t   log_q[$];
   int passes = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Bit 32 flags an illegal mnemonic.
   function automatic logic [32:0] model_enc(input item_t it);
      int iop [12] = '{0, 'h10, 'h11, 'h12, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h23, 'h2B, 0};
      int m = int'(it.mnem);
      longint w;
      if (m > 11) return {1'b1, 32'h0};
      if (m == 0)
         w = (longint'(it.rs) << 21) + (longint'(it.rt) << 16) + (longint'(it.rd) << 11)
           + (longint'(it.shamt) << 6) + longint'(it.funct);
      else if (m == 11)
         w = (longint'(1) << 26) + longint'(it.target);
      else
         w = (longint'(iop[m]) << 26) + (longint'(it.rs) << 21) + (longint'(it.rt) << 16)
           + longint'(it.imm);
      return {1'b0, w[31:0]};
   endfunction

   task automatic model(input logic [AW-1:0] base, output int n_use, output int cnt,
                        output bit f, output bit e);
      logic [AW:0] a;
      logic [32:0] w;
      bit stop;
      a = {1'b0, base}; cnt = 0; f = 0; e = 0; stop = 0; n_use = items.size();
      for (int i = 0; i < items.size() && !stop; i++) begin
         w = model_enc(items[i]);
         if (w[32]) begin
            e = 1;
            if (i == items.size()-1) begin n_use = i+1; stop = 1; end
         end else begin
            exp_q.push_back('{a[AW-1:0], w[31:0]});
            cnt++;
            if (i == items.size()-1) begin n_use = i+1; stop = 1; end
            else if (a == 2**AW-1) begin f = 1; n_use = i+1; stop = 1; end
            else a++;
         end
      end
   endtask

   task automatic drive(input item_t it);
      mnem = it.mnem; rs = it.rs; rt = it.rt; rd = it.rd; shamt = it.shamt;
      funct = it.funct; imm = it.imm; target = it.target;
   endtask

   function automatic item_t rnd_item(input logic [3:0] m);
      item_t it;
      it.mnem = m; it.rs = 5'($urandom); it.rt = 5'($urandom); it.rd = 5'($urandom);
      it.shamt = 5'($urandom); it.funct = 6'($urandom); it.imm = 16'($urandom);
      it.target = 26'($urandom);
      return it;
   endfunction

   function automatic item_t mk(input int m, input int s, input int t, input int d,
                                input int sh, input int fn, input int im, input int tg);
      item_t it;
      it.mnem = 4'(m); it.rs = 5'(s); it.rt = 5'(t); it.rd = 5'(d); it.shamt = 5'(sh);
      it.funct = 6'(fn); it.imm = 16'(im); it.target = 26'(tg);
      return it;
   endfunction

   // One load session: model predicts writes and final flags, compare process checks writes.
   task automatic run(input logic [AW-1:0] base, input string tag);
      int n_use, cnt, to;
      bit f, e;
      logic [32:0] w;
      log_q.delete();
      model(base, n_use, cnt, f, e);
      @(negedge clk); start = 1; base_addr = base;
      @(negedge clk); start = 0;
      for (int i = 0; i < n_use; i++) begin
         drive(items[i]);
         in_last = (i == items.size()-1);
         in_valid = 1;
         to = 0;
         while (!in_ready && to < 20) begin @(negedge clk); to++; end
         check({tag, "/accept_ready"}, in_ready, 1);
         @(negedge clk);
         in_valid = 0; in_last = 0;
         w = model_enc(items[i]);
         check({tag, "/we_latency"}, imem_we, !w[32]);
      end
      to = 0;
      while (!done && to < 20) begin @(negedge clk); to++; end
      check({tag, "/done"}, done, 1);
      check({tag, "/busy_fin"}, busy, 0);
      check({tag, "/count"}, count, cnt);
      check({tag, "/full"}, full, f);
      check({tag, "/err_illegal"}, err_illegal, e);
      // Offer more fields after the session: nothing may be accepted or written.
      drive(rnd_item(4'd1)); in_valid = 1;
      @(negedge clk);
      check({tag, "/idle_ready"}, in_ready, 0);
`ifdef INSTR_ENC_READBACK_EN
      check({tag, "/err_verify"}, err_verify, exp_verr);
`endif
      repeat (3) @(negedge clk);
      in_valid = 0;
      check({tag, "/drain"}, exp_q.size(), 0);
      check({tag, "/sticky_done"}, done, 1);
   endtask

   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
         end else begin
            wr_t ew;
            ew = exp_q.pop_front();
            check("wr_addr", imem_addr, ew.addr);
            check("wr_data", imem_wdata, ew.data);
         end
         log_q.push_back('{imem_addr, imem_wdata});
      end
   end

`ifdef INSTR_ENC_READBACK_EN
   always @(posedge clk) begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
      imem_rdata <= mem[imem_addr] ^ ((corrupt_en && imem_addr == corrupt_addr) ? 32'h1 : 32'h0);
   end
`endif

   initial begin
      rst = 1; start = 0; base_addr = '0; in_valid = 0; in_last = 0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef INSTR_ENC_READBACK_EN
      corrupt_en = 0; corrupt_addr = '0; exp_verr = 0;
`endif
      repeat (2) @(negedge clk);
      check("reset_outputs", {in_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err_illegal, count}, 0);
      rst = 0;
      @(negedge clk);

      items = '{mk(1, 1, 2, 0, 0, 0, 'h0005, 0)};
      run(8'h10, "addi");
      check("addi/log_n", log_q.size(), 1);
      if (log_q.size() > 0) check("addi/word", {log_q[0].addr, log_q[0].data}, {8'h10, 32'h40220005});

      items = '{mk(0, 3, 4, 5, 0, 'h20, 0, 0), mk(11, 0, 0, 0, 0, 0, 0, 'h40)};
      run(8'h20, "r_j");
      check("r_j/log_n", log_q.size(), 2);
      if (log_q.size() > 1) begin
         check("r_j/w0", {log_q[0].addr, log_q[0].data}, {8'h20, 32'h00642820});
         check("r_j/w1", {log_q[1].addr, log_q[1].data}, {8'h21, 32'h04000040});
      end

      items = '{mk(13, 1, 1, 1, 1, 1, 1, 1), mk(9, 0, 8, 0, 0, 0, 'h0004, 0)};
      run(8'h30, "illegal");
      check("illegal/log_n", log_q.size(), 1);
      if (log_q.size() > 0) check("illegal/word", {log_q[0].addr, log_q[0].data}, {8'h30, 32'h8C080004});

      items = '{mk(10, 1, 2, 0, 0, 0, 1, 0), mk(10, 1, 2, 0, 0, 0, 2, 0), mk(10, 1, 2, 0, 0, 0, 3, 0)};
      run(8'hFE, "full");
      check("full/log_n", log_q.size(), 2);
      if (log_q.size() > 1) check("full/addrs", {log_q[0].addr, log_q[1].addr}, {8'hFE, 8'hFF});

      items = '{mk(1, 0, 0, 0, 0, 0, 7, 0), mk(1, 0, 0, 0, 0, 0, 8, 0)};
      run(8'hFF, "top_base");
      check("top_base/log_n", log_q.size(), 1);

      // Reset lands on the edge that would accept BEQ: nothing may be written.
      @(negedge clk); start = 1; base_addr = 8'h40;
      @(negedge clk); start = 0;
      drive(mk(4, 1, 2, 0, 0, 0, 3, 0)); in_valid = 1; in_last = 1; rst = 1;
      @(negedge clk); in_valid = 0; in_last = 0;
      check("rst_mid/outputs", {in_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err_illegal, count}, 0);
      rst = 0;
      repeat (3) @(negedge clk);
      check("rst_mid/busy", busy, 0);
      items = '{mk(4, 1, 2, 0, 0, 0, 3, 0)};
      run(8'h40, "after_rst");

`ifdef INSTR_ENC_READBACK_EN
      items = '{mk(1, 1, 2, 0, 0, 0, 1, 0), mk(5, 1, 2, 0, 0, 0, 3, 0), mk(10, 1, 2, 0, 0, 0, 4, 0)};
      corrupt_en = 1; corrupt_addr = 8'h51; exp_verr = 1;
      run(8'h50, "verify_bad");
      if (log_q.size() > 1) check("verify_bad/bne", log_q[1].data, 32'h24220003);
      corrupt_en = 0; exp_verr = 0;
      run(8'h60, "verify_ok");
`endif

      for (int s = 0; s < 25; s++) begin
         int n;
         logic [AW-1:0] b;
         logic [3:0] m;
         items.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            m = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            items.push_back(rnd_item(m));
         end
         b = ($urandom_range(0, 3) == 0) ? AW'(256 - $urandom_range(1, 4)) : AW'($urandom);
         run(b, $sformatf("rnd%0d", s));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Encoder and instruction-memory loader; it is the write-side counterpart of the opcode decoder in the control unit. It accepts symbolic instruction fields over a valid/ready stream and packs them into 32-bit instruction words using the team opcode map. It writes the words sequentially into instruction memory from a programmable base address. It is used by the boot/test loader so that programs reach IMEM already in the exact encoding the control unit decodes.

Parameters:
ADDR_W, 8, IMEM word-address width; capacity is 2**ADDR_W words.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; sample base_addr and begin a load session
base_addr  in  ADDR_W  first IMEM word address
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept fields
in_last  in  1  current instruction is the final one of the program
mnem  in  4  0 R, 1 ADDI, 2 SUBI, 3 ANDI, 4 BEQ, 5 BNE, 6 BGT, 7 BGE, 8 BLE, 9 LW, 10 SW, 11 J, 12-15 illegal
rs, rt, rd  in  5 each  register fields
shamt  in  5  shift amount (R only)
funct  in  6  function field (R only)
imm  in  16  immediate/offset (I-types)
target  in  26  jump target (J)
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  encoded word
busy  out  1  session active
done  out  1  sticky; last word written or memory full
full  out  1  sticky; write to address 2**ADDR_W-1 occurred before in_last
err_illegal  out  1  sticky; illegal mnem seen
count  out  ADDR_W+1  words written this session

Behaviour:
- Reset: state IDLE; every output 0; internal address and word registers 0.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-types: {op, rs, rt, imm}, where ADDI=010000, SUBI=010001, ANDI=010010, BEQ=001000, BNE=001001, BGT=001010, BGE=001011, BLE=001100, LW=100011, SW=101011.
  - J: {6'b000001, target}. JAL and JR are not encodable; opcode 000001 is reserved for J only.
- FSM IDLE: in_ready=0. On start, load addr<=base_addr, clear done/full/err_illegal/count, go to ACCEPT. start is ignored outside IDLE.
- FSM ACCEPT: in_ready=1, busy=1. On in_valid&in_ready:
  - Legal mnem: register the encoded word, register the last flag, go to WRITE.
  - Illegal mnem: set err_illegal, drop the fields, remain in ACCEPT; the address does not advance. If in_last is set, go to FIN.
- FSM WRITE: in_ready=0; imem_we=1 for exactly one cycle with the registered addr/wdata; count++.
  - If last: go to FIN.
  - Else if addr==2**ADDR_W-1: set full, go to FIN.
  - Else: addr++, go to ACCEPT.
- FSM FIN: done=1, busy=0, go to IDLE. done, full and err_illegal hold until the next start or rst.
- Throughput: one word per 2 cycles. Latency from the accept edge to the imem_we cycle is 1 cycle.
- No address wrap-around: a session never writes past the top address.
- A base_addr at the top address allows exactly one write.
- rst mid-session: abort immediately, no further imem_we, all outputs 0.

Optional Feature:
Macro INSTR_ENC_READBACK_EN.
- When defined, add input imem_rdata[31:0] (1-cycle read latency, same address as imem_addr), output err_verify (sticky), and state VERIFY inserted after WRITE. VERIFY holds imem_addr for one read cycle, then compares imem_rdata to the written word; a mismatch sets err_verify. Throughput becomes one word per 3 cycles.
- When not defined, there is no port, no state, and throughput is unchanged.

Decomposition:
- Shared package mips_isa_pkg: 6-bit opcode constants for all listed opcodes, the 4-bit mnem enum, field widths/positions, and the FSM state enum. The control unit must use the same opcode constants.
- One natural sub-module: instr_field_packer, purely combinational, (mnem, fields) -> (word, illegal).

Test Plan:
- start, base_addr=0x10; send ADDI rs=1 rt=2 imm=0x0005 with in_last -> imem_we at addr 0x10, wdata 0x40220005; done=1, count=1.
- Send R rs=3 rt=4 rd=5 shamt=0 funct=0x20, then J target=0x0000040 with in_last -> words 0x00642820 @base, 0x04000040 @base+1; count=2.
- Send mnem=13 then LW rs=0 rt=8 imm=0x0004 with in_last -> err_illegal=1; single write 0x8C080004 at base_addr.
- ADDR_W=4, base_addr=14, send 3 non-last SW -> writes at 14 and 15, then full=1, done=1, no third imem_we.
- Assert rst one cycle after accepting BEQ -> no imem_we follows; all outputs 0 next cycle; a new start works normally.
- With INSTR_ENC_READBACK_EN, force imem_rdata corrupted for the BNE word (expected 0x24220003 for rs=1 rt=2 imm=3) -> err_verify=1; other words pass.
